// File: rtl/requant_pipe.sv
// requant_pipe: three-stage integer requantizer (shift, SRDHM, rounding
// divide, zero point, clamp) with one global advance for all stages.
module requant_pipe #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     in_acc,
    input  logic signed [WIDTH-1:0]     in_mult,
    input  logic signed [5:0]           in_shift,
    input  logic signed [WIDTH-1:0]     in_zp,
    input  logic signed [OUT_WIDTH-1:0] act_min,
    input  logic signed [OUT_WIDTH-1:0] act_max,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data
);

    localparam int XW = WIDTH + 32;
    localparam int PW = 2 * WIDTH;
    localparam int ZW = WIDTH + 1;

    localparam logic signed [WIDTH-1:0] WMAX =
        {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] WMIN =
        {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] WONE =
        {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [WIDTH-1:0] WZERO = '0;
    localparam logic signed [XW-1:0] XMAX =
        {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] XMIN =
        {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] NUDGE_P =
        {{(WIDTH+1){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
    localparam logic signed [PW-1:0] NUDGE_N =
        {{(WIDTH+2){1'b1}}, {(WIDTH-3){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0] TBIAS =
        {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] PZERO = '0;

    logic                    advance;
    logic                    s1_v, s2_v, s3_v;
    logic signed [WIDTH-1:0] s1_x, s1_mult, s1_zp;
    logic [5:0]              s1_rsh;
    logic signed [WIDTH-1:0] s2_h, s2_zp;
    logic [5:0]              s2_rsh;

    assign advance   = !s3_v || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_v;

    // S1: split the signed shift and saturate the left-shifted accumulator
    logic [5:0]              lsh, rsh;
    logic signed [XW-1:0]    acc_sh;
    logic signed [WIDTH-1:0] x_sat;

    always_comb begin
        lsh = '0;
        rsh = '0;
        if (in_shift[5]) begin
            rsh = -in_shift;
        end else begin
            lsh = in_shift;
        end
        acc_sh = {{32{in_acc[WIDTH-1]}}, in_acc} <<< lsh;
        x_sat  = acc_sh[WIDTH-1:0];
        if (acc_sh > XMAX) begin
            x_sat = WMAX;
        end else if (acc_sh < XMIN) begin
            x_sat = WMIN;
        end
    end

    // S2: rounding doubling high multiply, quotient truncated toward zero
    logic signed [PW-1:0]    prod, psum, pbias;
    logic signed [WIDTH-1:0] h_n;

    always_comb begin
        prod  = PW'(s1_x) * PW'(s1_mult);
        psum  = prod + (prod[PW-1] ? NUDGE_N : NUDGE_P);
        pbias = psum + (psum[PW-1] ? TBIAS : PZERO);
        h_n   = WIDTH'(pbias >>> (WIDTH-1));
        if (s1_x == WMIN && s1_mult == WMIN) begin
            h_n = WMAX;
        end
    end

    // S3: round-half-away divide, zero point in ZW bits, clamp
    logic [WIDTH-1:0]            mask, rem, thr;
    logic signed [WIDTH-1:0]     hsh, q;
    logic signed [ZW-1:0]        zsum, lo, hi, zcl;
    logic signed [OUT_WIDTH-1:0] o_n;

    always_comb begin
        mask = ~({WIDTH{1'b1}} << s2_rsh);
        rem  = s2_h & mask;
        thr  = (mask >> 1) + {{(WIDTH-1){1'b0}}, s2_h[WIDTH-1]};
        hsh  = s2_h >>> s2_rsh;
        q    = hsh + ((rem > thr) ? WONE : WZERO);
        zsum = {q[WIDTH-1], q} + {s2_zp[WIDTH-1], s2_zp};
        lo   = {{(ZW-OUT_WIDTH){act_min[OUT_WIDTH-1]}}, act_min};
        hi   = {{(ZW-OUT_WIDTH){act_max[OUT_WIDTH-1]}}, act_max};
        zcl  = zsum;
        if (zsum < lo) begin
            zcl = lo;
        end else if (zsum > hi) begin
            zcl = hi;
        end
        o_n = OUT_WIDTH'(zcl);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s2_v     <= 1'b0;
            s3_v     <= 1'b0;
            s1_x     <= '0;
            s1_mult  <= '0;
            s1_zp    <= '0;
            s1_rsh   <= '0;
            s2_h     <= '0;
            s2_zp    <= '0;
            s2_rsh   <= '0;
            out_data <= '0;
        end else if (advance) begin
            s1_v <= in_valid;
            s2_v <= s1_v;
            s3_v <= s2_v;
            if (in_valid) begin
                s1_x    <= x_sat;
                s1_mult <= in_mult;
                s1_zp   <= in_zp;
                s1_rsh  <= rsh;
            end
            if (s1_v) begin
                s2_h   <= h_n;
                s2_zp  <= s1_zp;
                s2_rsh <= s1_rsh;
            end
            if (s2_v) begin
                out_data <= o_n;
            end
        end
    end

endmodule

// File: tb/tb_requant_pipe.sv
// tb_requant_pipe: directed vectors for requant_pipe, checked with
// immediate assertions; latency, stall, and reset behaviour included.
module tb_requant_pipe;

    localparam int W  = 32;
    localparam int OW = 8;
    localparam int Q30 = 32'h4000_0000;
    localparam int MINI = 32'h8000_0000;
    localparam int MAXI = 32'h7fff_ffff;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [W-1:0]  in_acc = '0;
    logic signed [W-1:0]  in_mult = '0;
    logic signed [5:0]    in_shift = '0;
    logic signed [W-1:0]  in_zp = '0;
    logic signed [OW-1:0] act_min = -8'sd128;
    logic signed [OW-1:0] act_max = 8'sd127;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int idx, n, it;
    int got [8];

    requant_pipe #(.WIDTH(W), .OUT_WIDTH(OW)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_acc   (in_acc),
        .in_mult  (in_mult),
        .in_shift (in_shift),
        .in_zp    (in_zp),
        .act_min  (act_min),
        .act_max  (act_max),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int acc, input int mult,
                        input int sh, input int zp);
        in_valid = 1'b1;
        in_acc   = acc;
        in_mult  = mult;
        in_shift = sh[5:0];
        in_zp    = zp;
    endtask

    // beat driven at a negedge; result must show up exactly 3 edges later
    task automatic expect_out(input int exp, input string tag);
        #1;
        chk({tag, ".ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".lat1"}, out_valid, 0);
        @(negedge clk);
        chk({tag, ".lat2"}, out_valid, 0);
        @(negedge clk);
        chk({tag, ".lat3"}, out_valid, 1);
        chk({tag, ".data"}, out_data, exp);
    endtask

    task automatic run_one(input int acc, input int mult, input int sh,
                           input int zp, input int exp, input string tag);
        @(negedge clk);
        send(acc, mult, sh, zp);
        expect_out(exp, tag);
    endtask

    initial begin
        #3;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);

        // first edge after reset release takes a beat
        rst_n = 1'b1;
        send(100, Q30, 0, 0);
        expect_out(50, "basic");

        run_one(-3, Q30, -1, 0, -1, "tie_neg1");
        run_one(6, Q30, -1, 0, 2, "tie_pos");
        run_one(-6, Q30, -1, 0, -2, "tie_neg2");
        run_one(MINI, MINI, -24, 0, 127, "minmin");
        act_max = 8'sd100;
        run_one(MINI, MINI, -24, 0, 100, "minmin_max100");
        act_max = 8'sd127;
        run_one(200, Q30, 0, -20, 80, "zp");
        run_one(Q30, 100, 2, 0, 100, "lsat_pos");
        run_one(-Q30, 100, 2, 0, -100, "lsat_neg");
        run_one(25, Q30, 2, 0, 50, "lshift");
        run_one(-1000, Q30, 0, 0, -128, "clamp_lo");
        run_one(100, Q30, 0, MAXI, 127, "zp_nowrap");

        // stall: out_ready low, inputs offered every cycle
        @(negedge clk);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_acc   = 2 * (10 + idx);
            in_mult  = Q30;
            in_shift = '0;
            in_zp    = '0;
            #1;
            if (c >= 3) begin
                chk("stall.hold_v", out_valid, 1);
                chk("stall.hold_d", out_data, 10);
            end
            if (in_ready) idx++;
            @(negedge clk);
        end
        chk("stall.accepted", idx, 3);

        out_ready = 1'b1;
        n = 0;
        it = 0;
        while (n < 8 && it < 40) begin
            in_valid = (idx < 8);
            in_acc   = 2 * (10 + idx);
            #1;
            if (out_valid) begin
                got[n] = int'(out_data);
                n++;
            end
            if (in_valid && in_ready) idx++;
            it++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("drain.count", n, 8);
        chk("drain.cycles", it, 8);
        chk("drain.accepted", idx, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain.order%0d", k), got[k], 10 + k);
        end

        // reset while beats are in flight
        out_ready = 1'b0;
        send(20, Q30, 0, 0);
        @(negedge clk);
        send(22, Q30, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid.pre_valid", out_valid, 1);
        chk("mid.pre_data", out_data, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.rst_valid", out_valid, 0);
        chk("mid.rst_ready", in_ready, 1);
        chk("mid.rst_data", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("mid.quiet%0d", c), out_valid, 0);
        end
        run_one(-200, Q30, 0, 3, -97, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
